// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector
//   Collects entropy from free-running ring oscillators and packs it into words.
//   Each raw_i bit passes through a two-flop synchroniser; the synchronised bits
//   are XOR-folded into one sample bit. In RUN, a programmable divider picks
//   sample instants. Every sample feeds a repetition-count health test. An
//   optional von Neumann debiaser sits in front of an LSB-first packer, which
//   hands full words to a valid/ready output register.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   en_i          collection enable (IDLE <-> RUN)
//   vn_en_i       von Neumann debiaser enable
//   div_i         sample period minus one, in clk_i cycles
//   raw_i         asynchronous ring-oscillator outputs
//   clear_fail_i  clears a latched health failure (FAIL -> IDLE)
//   ready_i       consumer accepts data_o
//   data_o        random word
//   valid_o       data_o holds an unconsumed word
//   health_fail_o sticky repetition-count failure flag
//   ring_rst_o    active-high reset to the ring oscillators
module trng_entropy_collector #(
  parameter int unsigned NUM_RINGS  = 3,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned RCT_CUTOFF = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  vn_en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [NUM_RINGS-1:0]  raw_i,
  input  logic                  clear_fail_i,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  health_fail_o,
  output logic                  ring_rst_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam int unsigned      CNT_W     = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WORD_WIDTH);
  localparam logic [7:0]       RCT_LIMIT = 8'(RCT_CUTOFF);

  logic [NUM_RINGS-1:0]  sync1, sync2;
  logic                  sample_bit;
  logic [1:0]            state, state_nxt;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic                  sample_take;
  logic [7:0]            rct_cnt, rct_nxt;
  logic                  prev_bit;
  logic                  rct_fail;
  logic                  vn_phase, vn_first;
  logic                  emit, emit_bit;
  logic [WORD_WIDTH-1:0] pack;
  logic [CNT_W-1:0]      pack_cnt;
  logic                  pack_full;
  logic                  load;
  logic                  leaving;

  assign sample_bit  = ^sync2;
  assign sample_take = (state == ST_RUN) && (div_cnt == div_i);

  // A zero count means no sample history yet, so the next sample starts a run of 1.
  assign rct_nxt  = ((rct_cnt != 8'd0) && (sample_bit == prev_bit)) ? rct_cnt + 8'd1 : 8'd1;
  assign rct_fail = sample_take && (rct_nxt >= RCT_LIMIT);

  assign leaving   = (state == ST_RUN) && (state_nxt != ST_RUN);
  assign pack_full = (pack_cnt == CNT_FULL);
  assign load      = pack_full && (!valid_o || ready_i);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (rct_fail)  state_nxt = ST_FAIL;
        else if (!en_i) state_nxt = ST_IDLE;
      end
      ST_FAIL: if (clear_fail_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Debiaser: the first sample of a pair is held; the second decides the output.
  always_comb begin
    emit     = 1'b0;
    emit_bit = sample_bit;
    if (sample_take) begin
      if (!vn_en_i) begin
        emit = 1'b1;
      end else if (vn_phase && (vn_first != sample_bit)) begin
        emit     = 1'b1;
        emit_bit = vn_first;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1         <= '0;
      sync2         <= '0;
      state         <= ST_IDLE;
      ring_rst_o    <= 1'b1;
      div_cnt       <= '0;
      rct_cnt       <= '0;
      prev_bit      <= 1'b0;
      health_fail_o <= 1'b0;
      vn_phase      <= 1'b0;
      vn_first      <= 1'b0;
      pack          <= '0;
      pack_cnt      <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
    end else begin
      sync1      <= raw_i;
      sync2      <= sync1;
      state      <= state_nxt;
      ring_rst_o <= (state != ST_RUN);

      if ((state != ST_RUN) || leaving) div_cnt <= '0;
      else if (div_cnt == div_i)        div_cnt <= '0;
      else                              div_cnt <= div_cnt + 1'b1;

      if ((state == ST_FAIL) && clear_fail_i) begin
        rct_cnt  <= '0;
        prev_bit <= 1'b0;
      end else if (sample_take) begin
        rct_cnt  <= rct_nxt;
        prev_bit <= sample_bit;
      end

      if (rct_fail)                                health_fail_o <= 1'b1;
      else if ((state == ST_FAIL) && clear_fail_i) health_fail_o <= 1'b0;

      if ((state != ST_RUN) || leaving) begin
        vn_phase <= 1'b0;
      end else if (sample_take && vn_en_i) begin
        vn_phase <= ~vn_phase;
        if (!vn_phase) vn_first <= sample_bit;
      end

      // A full packer hands off in the same cycle a new bit arrives, so that
      // bit becomes bit 0 of the next word rather than being lost.
      if ((state != ST_RUN) || leaving) begin
        pack     <= '0;
        pack_cnt <= '0;
      end else if (load) begin
        pack     <= {{(WORD_WIDTH-1){1'b0}}, emit & emit_bit};
        pack_cnt <= {{(CNT_W-1){1'b0}}, emit};
      end else if (emit && !pack_full) begin
        pack     <= pack | ({{(WORD_WIDTH-1){1'b0}}, emit_bit} << pack_cnt);
        pack_cnt <= pack_cnt + CNT_ONE;
      end

      if (load) begin
        data_o  <= pack;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_entropy_collector.sv
// Directed bench for trng_entropy_collector (WORD_WIDTH=8, RCT_CUTOFF=4).
// Stimulus pushes hand-computed words into exp_q; the monitor pops and
// compares whenever a word is handed over (valid_o && ready_i).
module tb_trng_entropy_collector;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en_i = 1'b0;
  logic       vn_en_i = 1'b0;
  logic [7:0] div_i = 8'd0;
  logic [2:0] raw_i = 3'd0;
  logic       clear_fail_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       health_fail_o;
  logic       ring_rst_o;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  trng_entropy_collector #(
    .NUM_RINGS(3),
    .WORD_WIDTH(8),
    .DIV_WIDTH(8),
    .RCT_CUTOFF(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .vn_en_i(vn_en_i),
    .div_i(div_i),
    .raw_i(raw_i),
    .clear_fail_i(clear_fail_i),
    .ready_i(ready_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .health_fail_o(health_fail_o),
    .ring_rst_o(ring_rst_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just before each rising edge, when inputs and outputs are settled.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_ni && valid_o) vcount++;
      if (rst_ni && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%0h expected=none", data_o);
        end else begin
          e = exp_q.pop_front();
          check("word", {24'd0, data_o}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    en_i = 1'b0;
    clear_fail_i = 1'b0;
    raw_i = 3'd0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Sample i of string s equals s[i]; each value is held h cycles (div_i = h-1).
  // en_i rises at step 1 and falls once the last sample has been taken.
  task automatic run_stream(input string s, input int unsigned h, input logic inv);
    int unsigned n;
    logic last;
    logic b;
    n = s.len();
    div_i = 8'(h - 1);
    last = (s.getc(n - 1) == 8'd49);
    for (int unsigned c = 0; c <= h * n + 2; c++) begin
      @(negedge clk);
      if (c / h < n) b = (s.getc(c / h) == 8'd49);
      else b = ~last;
      raw_i = {inv, 1'b0, b};
      if (c == 1) en_i = 1'b1;
      if (c == h * n + 2) en_i = 1'b0;
      if (c == 3) check("ring_rst_run", {31'd0, ring_rst_o}, 32'd0);
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int v0;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_health", {31'd0, health_fail_o}, 32'd0);
    check("rst_ring_rst", {31'd0, ring_rst_o}, 32'd1);

    // Toggling ring 0, no debias: 0xAA words, one-cycle valid pulses
    do_reset();
    ready_i = 1'b1;
    vn_en_i = 1'b0;
    repeat (4) exp_q.push_back(8'hAA);
    v0 = vcount;
    run_stream("01010101010101010101010101010101", 1, 1'b0);
    drain();
    check("valid_cycles", vcount - v0, 32'd4);
    check("toggle_health", {31'd0, health_fail_o}, 32'd0);

    // Ring 2 held high inverts every sample: 0x55
    do_reset();
    repeat (2) exp_q.push_back(8'h55);
    run_stream("0101010101010101", 1, 1'b1);
    drain();

    // Debiaser: pairs 11,01,10,00,... emit 0,1,1,1,0,0,1,0
    do_reset();
    vn_en_i = 1'b1;
    exp_q.push_back(8'h4E);
    run_stream("1101100010111001011001", 1, 1'b0);
    drain();
    vn_en_i = 1'b0;

    // Repetition count test with constant input
    do_reset();
    div_i = 8'd0;
    raw_i = 3'd0;
    @(negedge clk);
    en_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rct_before", {31'd0, health_fail_o}, 32'd0);
    @(negedge clk);
    check("rct_trip", {31'd0, health_fail_o}, 32'd1);
    check("ring_rst_lag", {31'd0, ring_rst_o}, 32'd0);
    @(negedge clk);
    check("ring_rst_fail", {31'd0, ring_rst_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("fail_sticky", {31'd0, health_fail_o}, 32'd1);
    en_i = 1'b0;
    clear_fail_i = 1'b1;
    @(negedge clk);
    clear_fail_i = 1'b0;
    check("fail_clear", {31'd0, health_fail_o}, 32'd0);
    check("ring_rst_idle", {31'd0, ring_rst_o}, 32'd1);
    exp_q.push_back(8'h53);
    run_stream("11001010", 1, 1'b0);
    drain();

    // Backpressure: A pending, B full and blocked, 6 bits dropped, then D
    do_reset();
    ready_i = 1'b0;
    exp_q.push_back(8'h59);
    exp_q.push_back(8'hE6);
    exp_q.push_back(8'h4D);
    fork
      run_stream("100110100110011100101110110010", 1, 1'b0);
      begin
        repeat (21) @(negedge clk);
        check("hold_data", {24'd0, data_o}, 32'h59);
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        repeat (4) @(negedge clk);
        ready_i = 1'b1;
      end
    join
    drain();

    // Divided sampling; partial word dropped when en_i falls
    do_reset();
    ready_i = 1'b1;
    run_stream("11010", 4, 1'b0);
    exp_q.push_back(8'h36);
    run_stream("01101100", 4, 1'b0);
    drain();

    // Asynchronous reset with a word pending
    do_reset();
    ready_i = 1'b0;
    fork
      run_stream("101100111001", 1, 1'b0);
      begin
        repeat (15) @(negedge clk);
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        check("pre_rst_data", {24'd0, data_o}, 32'hCD);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_valid", {31'd0, valid_o}, 32'd0);
        check("async_data", {24'd0, data_o}, 32'd0);
        check("async_ring_rst", {31'd0, ring_rst_o}, 32'd1);
      end
    join
    @(negedge clk);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(8'hB2);
    run_stream("01001101", 1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
